// File: rtl/read_burst_ctrl_if.sv
// read_burst_ctrl_if: user-control inputs, FIFO status and strobe/status outputs of the read-burst sequencer
interface read_burst_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              rd_req;
    logic              burst_req;
    logic              abort;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              rd_single;
    logic              rd_burst;
    logic              busy;
    logic              done;
    logic              underrun;
    logic [DATA_W-1:0] remaining;

    modport master (
        output rd_req, burst_req, abort, fifo_empty, fifo_head,
        input  rd_single, rd_burst, busy, done, underrun, remaining
    );

    modport slave (
        input  rd_req, burst_req, abort, fifo_empty, fifo_head,
        output rd_single, rd_burst, busy, done, underrun, remaining
    );
endinterface

// File: rtl/read_burst_ctrl.sv
// read_burst_ctrl: issues single FIFO read strobes or PERIOD-spaced bursts whose length is the FIFO head word
module read_burst_ctrl #(
    parameter int DATA_W          = 4,
    parameter int PERIOD          = 100_000_000,
    parameter bit FIRST_IMMEDIATE = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    read_burst_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] START = FIRST_IMMEDIATE ? LAST : '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              single_q, single_d;
    logic              burst_q, burst_d;
    logic              done_q, done_d;
    logic              under_q, under_d;
    logic              loadable;

    // A burst can (re)start only from a non-empty FIFO holding a non-zero count.
    assign loadable = bus.burst_req & ~bus.fifo_empty & (bus.fifo_head != '0);

    // State, counters and every output are held in flops; reset clears them without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            single_q <= 1'b0;
            burst_q  <= 1'b0;
            done_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            single_q <= single_d;
            burst_q  <= burst_d;
            done_q   <= done_d;
            under_q  <= under_d;
        end
    end

    // Next state and next output values; in RUN abort beats retrigger, which beats the period tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        single_d = 1'b0;
        burst_d  = 1'b0;
        done_d   = 1'b0;
        under_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (loadable) begin
                    state_d = RUN;
                    rem_d   = bus.fifo_head;
                    cnt_d   = START;
                end else if (bus.burst_req) begin
                    done_d = ~bus.fifo_empty;
                end else begin
                    single_d = bus.rd_req & ~bus.fifo_empty;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (loadable) begin
                    rem_d = bus.fifo_head;
                    cnt_d = START;
                end else if (bus.burst_req) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bus.fifo_empty) begin
                        state_d = IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        under_d = 1'b1;
                    end else begin
                        burst_d = 1'b1;
                        rem_d   = rem_q - DATA_W'(1);
                        done_d  = (rem_q == DATA_W'(1));
                        state_d = (rem_q == DATA_W'(1)) ? IDLE : RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_single = single_q;
    assign bus.rd_burst  = burst_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.underrun  = under_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_read_burst_ctrl.sv
// tb_read_burst_ctrl: vector table, directed corner sequences and random traffic against a schedule-based model
module tb_read_burst_ctrl;
    localparam int P = 4;

    typedef struct {
        logic       rr, br, ab, em;
        logic [3:0] hd;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   strb [2];
    bit   m_active [2];
    int   m_left [2];
    int   m_next [2];
    logic [8:0] m_out [2];
    logic in_rr, in_br, in_ab, in_em;
    logic [3:0] in_hd;
    vec_t tbl [$];

    read_burst_ctrl_if #(.DATA_W(4)) b0();
    read_burst_ctrl_if #(.DATA_W(4)) b1();

    read_burst_ctrl #(.DATA_W(4), .PERIOD(P), .FIRST_IMMEDIATE(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    read_burst_ctrl #(.DATA_W(4), .PERIOD(P), .FIRST_IMMEDIATE(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always #5 clk = ~clk;

    function automatic logic [8:0] got0();
        return {b0.rd_single, b0.rd_burst, b0.busy, b0.done, b0.underrun, b0.remaining};
    endfunction

    function automatic logic [8:0] got1();
        return {b1.rd_single, b1.rd_burst, b1.busy, b1.done, b1.underrun, b1.remaining};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a burst is a list of strobe instants, first at start+(1 or PERIOD), then every PERIOD edges.
    task automatic model_edge(input int i);
        bit s = 0, b = 0, d = 0, u = 0;
        bit ok_load = in_br && !in_em && in_hd != 0;
        int first = (i == 1) ? 1 : P;
        if (!m_active[i]) begin
            if (ok_load) begin
                m_active[i] = 1; m_left[i] = in_hd; m_next[i] = edge_n + first;
            end else if (in_br) d = !in_em;
            else s = in_rr && !in_em;
        end else if (in_ab) begin
            m_active[i] = 0; m_left[i] = 0; d = 1;
        end else if (ok_load) begin
            m_left[i] = in_hd; m_next[i] = edge_n + first;
        end else if (in_br) begin
            m_active[i] = 0; m_left[i] = 0; d = 1;
        end else if (edge_n == m_next[i]) begin
            if (in_em) begin
                m_active[i] = 0; m_left[i] = 0; d = 1; u = 1;
            end else begin
                b = 1; m_left[i]--; m_next[i] += P;
                if (m_left[i] == 0) begin m_active[i] = 0; d = 1; end
            end
        end
        m_out[i] = {s, b, m_active[i], d, u, 4'(m_left[i])};
    endtask

    task automatic step(input logic rr, input logic br, input logic ab, input logic em, input logic [3:0] hd);
        in_rr = rr; in_br = br; in_ab = ab; in_em = em; in_hd = hd;
        b0.rd_req = rr; b0.burst_req = br; b0.abort = ab; b0.fifo_empty = em; b0.fifo_head = hd;
        b1.rd_req = rr; b1.burst_req = br; b1.abort = ab; b1.fifo_empty = em; b1.fifo_head = hd;
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check("u0 vs model", 32'(got0()), 32'(m_out[0]));
        check("u1 vs model", 32'(got1()), 32'(m_out[1]));
        strb[0] += int'(b0.rd_burst);
        strb[1] += int'(b1.rd_burst);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic em, input logic [3:0] hd);
        repeat (n) step(1'b0, 1'b0, 1'b0, em, hd);
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check("async reset u0", 32'(got0()), 32'd0);
        check("async reset u1", 32'(got1()), 32'd0);
        for (int i = 0; i < 2; i++) begin m_active[i] = 0; m_left[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic rr, br, ab, em, input logic [3:0] hd, input logic [8:0] exp);
        tbl.push_back('{rr, br, ab, em, hd, exp});
    endfunction

    initial begin
        logic [5:0] smask, dmask;
        for (int i = 0; i < 2; i++) begin strb[i] = 0; m_active[i] = 0; m_left[i] = 0; m_next[i] = 0; end
        b0.rd_req = 0; b0.burst_req = 0; b0.abort = 0; b0.fifo_empty = 1; b0.fifo_head = 0;
        b1.rd_req = 0; b1.burst_req = 0; b1.abort = 0; b1.fifo_empty = 1; b1.fifo_head = 0;

        // Expected outputs of the FIRST_IMMEDIATE=0 instance: {single,burst,busy,done,underrun,remaining}
        add(1, 0, 0, 0, 3, 9'b1_0_0_0_0_0000);
        add(0, 0, 0, 0, 3, 9'b0);
        add(1, 0, 0, 1, 3, 9'b0);
        add(0, 1, 0, 0, 0, 9'b0_0_0_1_0_0000);
        add(0, 1, 0, 1, 3, 9'b0);
        add(1, 1, 0, 0, 3, {5'b00100, 4'd3});
        add(0, 0, 0, 0, 3, {5'b00100, 4'd3});
        add(1, 0, 0, 0, 3, {5'b00100, 4'd3});
        add(0, 0, 0, 0, 3, {5'b00100, 4'd3});
        add(0, 0, 0, 0, 3, {5'b01100, 4'd2});
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3, {5'b00100, 4'd2});
        add(1, 0, 0, 0, 3, {5'b01100, 4'd1});
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3, {5'b00100, 4'd1});
        add(0, 0, 0, 0, 3, {5'b01010, 4'd0});
        add(0, 0, 0, 0, 3, 9'b0);

        repeat (2) @(negedge clk);
        check("reset state u0", 32'(got0()), 32'd0);
        check("reset state u1", 32'(got1()), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].rr, tbl[k].br, tbl[k].ab, tbl[k].em, tbl[k].hd);
            check($sformatf("table row %0d", k), 32'(got0()), 32'(tbl[k].exp));
        end
        run(10, 0, 3);

        // Immediate first strobe: head=2 gives strobes one and five edges after start.
        step(0, 1, 0, 0, 2);
        for (int j = 0; j < 6; j++) begin
            step(0, 0, 0, 0, 2);
            smask[j] = b1.rd_burst;
            dmask[j] = b1.done;
        end
        check("immediate strobe cycles", 32'(smask), 32'(6'b010001));
        check("immediate done cycle", 32'(dmask), 32'(6'b010000));
        run(20, 0, 2);

        // Abort after the second strobe stops the burst at once.
        step(0, 1, 0, 0, 5);
        run(8, 0, 5);
        step(0, 0, 1, 0, 5);
        check("abort result", 32'(got0()), 32'({5'b00010, 4'd0}));
        strb[0] = 0;
        run(10, 0, 5);
        check("strobes after abort", 32'(strb[0]), 32'd0);
        run(20, 0, 5);

        // Retrigger after the first strobe reloads the count.
        step(0, 1, 0, 0, 5);
        run(4, 0, 5);
        step(0, 1, 0, 0, 2);
        strb[0] = 0;
        run(12, 0, 2);
        check("strobes after retrigger", 32'(strb[0]), 32'd2);
        run(20, 0, 2);

        // FIFO drains before the second tick: done and underrun together, no strobe.
        step(0, 1, 0, 0, 4);
        run(4, 0, 4);
        run(3, 1, 4);
        step(0, 0, 0, 1, 4);
        check("underrun result", 32'(got0()), 32'({5'b00011, 4'd0}));
        run(20, 0, 3);

        // Zero count: done only, busy stays low.
        step(0, 1, 0, 0, 0);
        check("zero head", 32'(got0()), 32'({5'b00010, 4'd0}));
        run(2, 0, 0);

        // Asynchronous reset mid-burst with two strobes still owed.
        step(0, 1, 0, 0, 3);
        run(4, 0, 3);
        check("before reset", 32'(got0()), 32'({5'b01100, 4'd2}));
        reset_mid();
        strb[0] = 0;
        strb[1] = 0;
        run(10, 0, 3);
        check("strobes after reset u0", 32'(strb[0]), 32'd0);
        check("strobes after reset u1", 32'(strb[1]), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(31) == 0,
                 $urandom_range(7) == 0, 4'($urandom_range(15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/read_burst_ctrl.md
# read_burst_ctrl

Parametrised read-pulse sequencer that sits between the debounced/edge-detected user controls and the FIFO read port. It issues single read strobes on request. On a burst request it samples a repeat count from the FIFO head and emits that many read strobes, one every PERIOD clocks. It adds abort, underrun detection, an optional immediate first strobe and status outputs.

## Interface
Parameters:
- DATA_W, 4, width of FIFO head word / repeat count
- PERIOD, 100_000_000, clocks between burst strobes (≥2)
- FIRST_IMMEDIATE, 0, 1 = first burst strobe issued 1 cycle after start instead of after PERIOD
- CNT_W (localparam), $clog2(PERIOD), period counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  single-read request, 1-cycle pulse
- burst_req  in  1  burst start/retrigger, 1-cycle pulse
- abort  in  1  terminate burst, 1-cycle pulse
- fifo_empty  in  1  FIFO empty flag
- fifo_head  in  DATA_W  current FIFO output word (repeat count)
- rd_single  out  1  single read strobe, 1 cycle
- rd_burst  out  1  burst read strobe, 1 cycle
- busy  out  1  high while in RUN
- done  out  1  1-cycle pulse at burst end (any cause)
- underrun  out  1  1-cycle pulse, burst ended by empty FIFO
- remaining  out  DATA_W  strobes still to issue

## Operation
- All outputs registered. While rst_n=0: state IDLE, counter 0, remaining 0, all outputs 0.
- States: IDLE, RUN.
- IDLE:
  - burst_req & ~fifo_empty & fifo_head≠0 → RUN; remaining←fifo_head; counter←(FIRST_IMMEDIATE ? PERIOD-1 : 0).
  - burst_req & ~fifo_empty & fifo_head=0 → stay IDLE, done pulse, no strobes.
  - burst_req & fifo_empty → ignored.
  - rd_req & ~fifo_empty & ~burst_req → rd_single pulse. rd_req with fifo_empty → ignored.
  - The count word is sampled, not popped.
- RUN, priority abort > burst_req > tick:
  - abort → IDLE, done=1, remaining←0, no strobe that cycle.
  - burst_req (retrigger) with ~fifo_empty & fifo_head≠0 → reload remaining and counter as at start; stay RUN. Otherwise → IDLE with done.
  - tick (counter=PERIOD-1) → counter←0. If fifo_empty: no strobe, done=1, underrun=1, IDLE. Else rd_burst=1, remaining←remaining-1. If remaining was 1: done=1, IDLE in the same edge.
  - Otherwise counter increments.
  - rd_req ignored in RUN (no rd_single).
- Counter never exceeds PERIOD-1. remaining never wraps below 0.

## Timing
- rd_single: high exactly 1 cycle, the cycle after the rd_req cycle.
- Burst start at edge k (burst_req sampled). busy=1 from k.
  - FIRST_IMMEDIATE=0: first rd_burst in the cycle after edge k+PERIOD.
  - FIRST_IMMEDIATE=1: first rd_burst after edge k+1.
  - Subsequent strobes every PERIOD cycles.
- Final strobe: rd_burst=1, done=1, busy=0, remaining=0 all in the same cycle.
- abort at edge k: done=1 and busy=0 in the cycle after k. A tick coinciding with abort produces no strobe.
- rd_req and burst_req in the same IDLE cycle: burst wins, rd_single not issued.
- rst_n low mid-burst: outputs clear immediately (asynchronous), no done pulse. Resume in IDLE after release.
- done and underrun never assert in consecutive cycles for a single burst.

## Test plan
- Reset: rst_n=0 mid-RUN with remaining=2 → all outputs 0 at once, busy=0, no rd_burst after release.
- Single read: fifo_empty=0, rd_req pulse → rd_single=1 for exactly 1 cycle. Repeat with fifo_empty=1 → no rd_single.
- Burst, PERIOD=4, FIRST_IMMEDIATE=0, fifo_head=3 → rd_burst at cycles 4, 8, 12 after start; remaining 3→2→1→0; done with 3rd strobe; rd_req during burst gives no rd_single.
- Immediate mode, FIRST_IMMEDIATE=1, PERIOD=4, fifo_head=2 → strobes at cycles 1 and 5; done at 5.
- Abort/retrigger: head=5, abort after 2nd strobe → done, remaining 0, no further strobes. Second run: retrigger with head=2 after 1st strobe → exactly 2 more strobes.
- Underrun and zero: fifo_empty rises before 2nd tick of head=4 burst → no strobe, done=1 and underrun=1 together. fifo_head=0 burst_req → done only, busy stays 0.
